pantalla_refresh_spi: RTL and testbench

//  Frame reader for the display RAM: scans all pages/columns through the RAM byte read port and streams

---
 rtl/pantalla_refresh_spi.sv | 161 ++++++++++++++++
 tb/tb_pantalla_refresh_spi.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pantalla_refresh_spi.sv
// Frame reader: walks display RAM page by page and streams each page, preceded by a
// 3-byte address header, to an SSD1306-style panel over mode-0 SPI.
module pantalla_refresh_spi #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned PAGES   = 8,
    parameter int unsigned COLS    = 128
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    output logic                                   busy,
    output logic                                   done,
    output logic [$clog2(PAGES)+$clog2(COLS)-1:0]  addr_rd,
    output logic                                   rd,
    input  logic [7:0]                             ram_data,
    output logic                                   cs_n,
    output logic                                   dc,
    output logic                                   sclk,
    output logic                                   mosi
);

    localparam int unsigned PW = $clog2(PAGES);
    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DivLast  = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] ColLast  = CW'(COLS - 1);
    localparam logic [PW-1:0] PageLast = PW'(PAGES - 1);

    typedef enum logic [2:0] {
        StIdle, StHdrLoad, StShift, StRd, StDatLoad, StFin
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] page_q, page_d;
    logic [CW-1:0] col_q, col_d;
    logic [1:0]    hdr_q, hdr_d;      // 0..2 header byte index, 3 = data phase
    logic [2:0]    bit_q, bit_d;
    logic [DW-1:0] div_q, div_d;
    logic          phase_q, phase_d;  // 0 = sclk low half, 1 = sclk high half
    logic [7:0]    shreg_q, shreg_d;
    logic          dc_q, dc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            page_q  <= '0;
            col_q   <= '0;
            hdr_q   <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            phase_q <= 1'b0;
            shreg_q <= '0;
            dc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            col_q   <= col_d;
            hdr_q   <= hdr_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            phase_q <= phase_d;
            shreg_q <= shreg_d;
            dc_q    <= dc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        col_d   = col_q;
        hdr_d   = hdr_q;
        bit_d   = bit_q;
        div_d   = div_q;
        phase_d = phase_q;
        shreg_d = shreg_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StHdrLoad;
                    page_d  = '0;
                    col_d   = '0;
                    hdr_d   = '0;
                end
            end
            StHdrLoad: begin
                if (hdr_q == 2'd0)      shreg_d = 8'hB0 | 8'(page_q);
                else if (hdr_q == 2'd1) shreg_d = 8'h00;
                else                    shreg_d = 8'h10;
                div_d   = '0;
                phase_d = 1'b0;
                bit_d   = '0;
                state_d = StShift;
            end
            StRd: state_d = StDatLoad;
            StDatLoad: begin
                shreg_d = ram_data;
                div_d   = '0;
                phase_d = 1'b0;
                bit_d   = '0;
                state_d = StShift;
            end
            StShift: begin
                if (div_q == DivLast) begin
                    div_d   = '0;
                    phase_d = ~phase_q;
                    if (phase_q) begin
                        shreg_d = {shreg_q[6:0], 1'b0};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            if (hdr_q < 2'd2) begin
                                hdr_d   = hdr_q + 2'd1;
                                state_d = StHdrLoad;
                            end else if (hdr_q == 2'd2) begin
                                hdr_d   = 2'd3;
                                col_d   = '0;
                                state_d = StRd;
                            end else if (col_q != ColLast) begin
                                col_d   = col_q + CW'(1);
                                state_d = StRd;
                            end else if (page_q != PageLast) begin
                                page_d  = page_q + PW'(1);
                                hdr_d   = '0;
                                state_d = StHdrLoad;
                            end else begin
                                state_d = StFin;
                            end
                        end
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // dc settles on entry to each load state so it is stable before the first sclk rise.
    always_comb begin
        dc_d = dc_q;
        if (state_d == StDatLoad) begin
            dc_d = 1'b1;
        end else if (state_d == StHdrLoad || state_d == StFin || state_d == StIdle) begin
            dc_d = 1'b0;
        end
    end

    always_comb begin
        busy    = (state_q != StIdle) && (state_q != StFin);
        done    = (state_q == StFin);
        cs_n    = ~busy;
        rd      = (state_q == StRd);
        addr_rd = {page_q, col_q};
        dc      = dc_q;
        sclk    = (state_q == StShift) && phase_q;
        mosi    = (state_q == StShift) && shreg_q[7];
    end

endmodule

// File: tb/tb_pantalla_refresh_spi.sv
// Directed bench: a CLK_DIV=4 instance runs a full frame, a CLK_DIV=1 instance a short burst;
// SPI bytes are decoded from the pins and checked against hand-computed values.
module tb_pantalla_refresh_spi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, start_a, busy_a, done_a, rd_a, cs_n_a, dc_a, sclk_a, mosi_a;
    logic [9:0] addr_a;
    logic [7:0] ram_a;
    logic       rst_b, start_b, busy_b, done_b, rd_b, cs_n_b, dc_b, sclk_b, mosi_b;
    logic [9:0] addr_b;
    logic [7:0] ram_b;

    pantalla_refresh_spi #(.CLK_DIV(4), .PAGES(8), .COLS(128)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .busy(busy_a), .done(done_a),
        .addr_rd(addr_a), .rd(rd_a), .ram_data(ram_a), .cs_n(cs_n_a), .dc(dc_a),
        .sclk(sclk_a), .mosi(mosi_a)
    );

    pantalla_refresh_spi #(.CLK_DIV(1), .PAGES(8), .COLS(128)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
        .addr_rd(addr_b), .rd(rd_b), .ram_data(ram_b), .cs_n(cs_n_b), .dc(dc_b),
        .sclk(sclk_b), .mosi(mosi_b)
    );

    // RAM content byte = page*16 + col[3:0]; a junk value is driven when no read is pending.
    always @(posedge clk) ram_a <= rd_a ? {1'b0, addr_a[9:7], addr_a[3:0]} : 8'hA5;
    always @(posedge clk) ram_b <= rd_b ? {1'b0, addr_b[9:7], addr_b[3:0]} : 8'hA5;

    // Pin-level SPI decoders: capture {dc, byte} and the cycle of each byte's first sclk rise.
    int         cyc_a, bitn_a, t0_a, rd_cnt_a, rise_a, done_cnt_a, addr103_a;
    logic       sclk_pa = 1'b0;
    logic [7:0] sh_a;
    logic [8:0] q_a[$];
    int         t_a[$];

    always @(negedge clk) begin
        cyc_a++;
        if (rd_a === 1'b1) begin
            rd_cnt_a++;
            if (addr_a == 10'h103) addr103_a++;
        end
        if (done_a === 1'b1) done_cnt_a++;
        if (cs_n_a !== 1'b0) begin
            bitn_a = 0;
        end else if (sclk_a === 1'b1 && sclk_pa === 1'b0) begin
            rise_a++;
            if (bitn_a == 0) t0_a = cyc_a;
            sh_a = {sh_a[6:0], mosi_a};
            bitn_a++;
            if (bitn_a == 8) begin
                q_a.push_back({dc_a, sh_a});
                t_a.push_back(t0_a);
                bitn_a = 0;
            end
        end
        sclk_pa = sclk_a;
    end

    int         cyc_b, bitn_b, t0_b;
    logic       sclk_pb = 1'b0;
    logic [7:0] sh_b;
    logic [8:0] q_b[$];
    int         t_b[$];

    always @(negedge clk) begin
        cyc_b++;
        if (cs_n_b !== 1'b0) begin
            bitn_b = 0;
        end else if (sclk_b === 1'b1 && sclk_pb === 1'b0) begin
            if (bitn_b == 0) t0_b = cyc_b;
            sh_b = {sh_b[6:0], mosi_b};
            bitn_b++;
            if (bitn_b == 8) begin
                q_b.push_back({dc_b, sh_b});
                t_b.push_back(t0_b);
                bitn_b = 0;
            end
        end
        sclk_pb = sclk_b;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int k;
        int base_rd, base_rise, ncmd;
        logic [8:0] exp_b[8];

        start_a = 1'b0;
        start_b = 1'b0;
        rst_a   = 1'b0;
        rst_b   = 1'b0;
        #1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);
        chk("reset_pins", {cs_n_a, busy_a, done_a, rd_a, sclk_a, mosi_a, dc_a}, 7'b1000000);
        chk("reset_addr", addr_a, 10'h000);
        rst_a = 1'b0;
        @(negedge clk);

        // Reset in the middle of a byte must drop cs_n and kill the byte immediately.
        start_a = 1'b1;
        chk("busy_before_edge", busy_a, 1'b0);
        @(negedge clk);
        start_a = 1'b0;
        chk("busy_cs_after_start", {busy_a, cs_n_a, dc_a}, 3'b100);
        repeat (20) @(negedge clk);
        k = 0;
        while (sclk_a !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("t1_mid_byte_sclk_high", sclk_a, 1'b1);
        #2 rst_a = 1'b1;
        #1;
        chk("t1_abort_pins", {cs_n_a, sclk_a, rd_a, busy_a, done_a, mosi_a, dc_a}, 7'b1000000);
        @(negedge clk);
        rst_a = 1'b0;
        repeat (3) @(negedge clk);
        chk("t1_partial_discarded", q_a.size(), 0);

        // Full frame at CLK_DIV=4, with an ignored start pulse mid-frame.
        base_rd   = rd_cnt_a;
        base_rise = rise_a;
        start_a   = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        k = 0;
        while (done_a !== 1'b1 && k < 80000) begin
            @(negedge clk);
            k++;
            if (k == 1000) start_a = 1'b1;
            if (k == 1001) start_a = 1'b0;
        end
        chk("frame_len", k, 69144);
        chk("fin_pins", {busy_a, cs_n_a, dc_a, sclk_a, mosi_a}, 5'b01000);
        @(negedge clk);
        chk("done_one_cycle", {done_a, busy_a, cs_n_a}, 3'b001);
        repeat (300) @(negedge clk);
        chk("no_second_frame", busy_a, 1'b0);
        chk("done_count", done_cnt_a, 1);

        chk("byte_count", q_a.size(), 1048);
        chk("hdr0", q_a[0], 9'h0B0);
        chk("hdr1", q_a[1], 9'h000);
        chk("hdr2", q_a[2], 9'h010);
        chk("p0c0", q_a[3], 9'h100);
        chk("hdr_page5", q_a[655], 9'h0B5);
        chk("p2c3", q_a[268], 9'h123);
        chk("last_byte", q_a[1047], 9'h17F);
        ncmd = 0;
        foreach (q_a[i]) if (q_a[i][8] == 1'b0) ncmd++;
        chk("cmd_bytes", ncmd, 24);
        chk("rd_pulses", rd_cnt_a - base_rd, 1024);
        chk("rd_addr_103_once", addr103_a, 1);
        chk("sclk_rises", rise_a - base_rise, 8384);
        chk("cmd_byte_time", t_a[1] - t_a[0], 65);
        chk("hdr_to_data_time", t_a[3] - t_a[2], 66);
        chk("data_byte_time", t_a[4] - t_a[3], 66);

        // CLK_DIV=1: sclk toggles every clock, 16-clock bytes.
        rst_b = 1'b0;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        chk("b_busy", busy_b, 1'b1);
        k = 0;
        while (sclk_b !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("b_sclk_high", sclk_b, 1'b1);
        @(negedge clk);
        chk("b_sclk_low_next", sclk_b, 1'b0);
        @(negedge clk);
        chk("b_sclk_high_next", sclk_b, 1'b1);
        k = 0;
        while (q_b.size() < 8 && k < 500) begin
            @(negedge clk);
            k++;
        end
        exp_b = '{9'h0B0, 9'h000, 9'h010, 9'h100, 9'h101, 9'h102, 9'h103, 9'h104};
        for (int i = 0; i < 8; i++) chk($sformatf("b_byte%0d", i), q_b[i], exp_b[i]);
        chk("b_cmd_byte_time", t_b[1] - t_b[0], 17);
        chk("b_data_byte_time", t_b[4] - t_b[3], 18);
        rst_b = 1'b1;
        #1;
        chk("b_reset_pins", {cs_n_b, busy_b, done_b, sclk_b}, 4'b1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
